// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Builds instruction words from nibble entries, writes them to
//               instruction memory from address 0, and holds the processor in
//               reset while a load session is in progress.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [3:0]        nib_i,
    input  logic              nib_valid_i,
    input  logic              commit_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic              proc_hold_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W:0]   word_count_o,
    output logic [DATA_W-1:0] disp_word_o,
    output logic [1:0]        state_o
);

    localparam int                c_NIBS      = DATA_W / 4;
    localparam int                c_CNT_W     = (c_NIBS > 1) ? $clog2(c_NIBS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_NIB = c_CNT_W'(c_NIBS - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] c_ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   c_WCNT_ONE  = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENTRY = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [c_CNT_W-1:0]  nib_cnt_q, nib_cnt_d;
    logic                nv_prev_q;

    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                hold_q, hold_d;
    logic                done_q, done_d;

    logic                w_edge;

    assign w_edge = nib_valid_i & ~nv_prev_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            count_q   <= '0;
            word_q    <= '0;
            nib_cnt_q <= '0;
            nv_prev_q <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            hold_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            count_q   <= count_d;
            word_q    <= word_d;
            nib_cnt_q <= nib_cnt_d;
            nv_prev_q <= nib_valid_i;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            hold_q    <= hold_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        count_d   = count_q;
        word_d    = word_q;
        nib_cnt_d = nib_cnt_q;

        case (state_q)
            S_IDLE: begin
                // word_count and disp_word stay visible until the next session
                if (start_i) begin
                    state_d   = S_ENTRY;
                    addr_d    = '0;
                    count_d   = '0;
                    word_d    = '0;
                    nib_cnt_d = '0;
                end
            end
            S_ENTRY: begin
                if (commit_i) begin
                    state_d = S_DONE;
                end else if (w_edge) begin
                    word_d    = (word_q << 4) | DATA_W'(nib_i);
                    nib_cnt_d = nib_cnt_q + c_CNT_ONE;
                    if (nib_cnt_q == c_LAST_NIB) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                addr_d    = addr_q + c_ADDR_ONE;
                count_d   = count_q + c_WCNT_ONE;
                nib_cnt_d = '0;
                word_d    = '0;
                state_d   = (addr_q == c_LAST_ADDR) ? S_DONE : S_ENTRY;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output flops are loaded from the next state so they line up with state_q
    always_comb begin
        wr_en_d   = (state_d == S_WRITE);
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (state_d == S_WRITE) begin
            wr_addr_d = addr_q;
            wr_data_d = word_d;
        end
        hold_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    assign wr_en_o      = wr_en_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign proc_hold_o  = hold_q;
    assign busy_o       = hold_q;
    assign done_o       = done_q;
    assign word_count_o = count_q;
    assign disp_word_o  = word_q;
    assign state_o      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Randomized self-checking bench for imem_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int c_ADDR_W = 5;
    localparam int c_DATA_W = 16;
    localparam int c_DEPTH  = 2 ** c_ADDR_W;

    logic                clk;
    logic                rst;
    logic                r_start;
    logic [3:0]          r_nib;
    logic                r_nib_valid;
    logic                r_commit;
    logic                w_wr_en;
    logic [c_ADDR_W-1:0] w_wr_addr;
    logic [c_DATA_W-1:0] w_wr_data;
    logic                w_proc_hold;
    logic                w_busy;
    logic                w_done;
    logic [c_ADDR_W:0]   w_word_count;
    logic [c_DATA_W-1:0] w_disp_word;
    logic [1:0]          w_state;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [c_ADDR_W-1:0] a;
        logic [c_DATA_W-1:0] d;
    } wr_t;

    wr_t wq[$];

    imem_loader #(.ADDR_W(c_ADDR_W), .DATA_W(c_DATA_W)) u_dut (
        .clock_i      (clk),
        .reset_i      (rst),
        .start_i      (r_start),
        .nib_i        (r_nib),
        .nib_valid_i  (r_nib_valid),
        .commit_i     (r_commit),
        .wr_en_o      (w_wr_en),
        .wr_addr_o    (w_wr_addr),
        .wr_data_o    (w_wr_data),
        .proc_hold_o  (w_proc_hold),
        .busy_o       (w_busy),
        .done_o       (w_done),
        .word_count_o (w_word_count),
        .disp_word_o  (w_disp_word),
        .state_o      (w_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (w_wr_en) wq.push_back('{a: w_wr_addr, d: w_wr_data});
    end

    task automatic send_nib(input logic [3:0] v);
        r_nib       = v;
        r_nib_valid = 1'b1;
        @(negedge clk);
        r_nib_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [c_DATA_W-1:0] w);
        for (int i = 0; i < c_DATA_W / 4; i++) begin
            send_nib(4'(w >> (c_DATA_W - 4 - 4 * i)));
        end
    endtask

    task automatic do_start();
        r_start = 1'b1;
        @(negedge clk);
        r_start = 1'b0;
        checks++;
        if (w_state !== 2'd1 || w_busy !== 1'b1 || w_proc_hold !== 1'b1) begin
            errors++;
            $display("FAIL start: state=%0d busy=%b hold=%b, need state=1 busy=1 hold=1",
                     w_state, w_busy, w_proc_hold);
        end
    endtask

    task automatic do_commit(input int exp_cnt);
        r_commit = 1'b1;
        @(negedge clk);
        r_commit = 1'b0;
        checks++;
        if (w_done !== 1'b1 || w_state !== 2'd3 || w_proc_hold !== 1'b1) begin
            errors++;
            $display("FAIL commit_done: done=%b state=%0d hold=%b, need done=1 state=3 hold=1",
                     w_done, w_state, w_proc_hold);
        end
        @(negedge clk);
        checks++;
        if (w_done !== 1'b0 || w_proc_hold !== 1'b0 || w_state !== 2'd0) begin
            errors++;
            $display("FAIL commit_release: done=%b hold=%b state=%0d, need 0/0/0",
                     w_done, w_proc_hold, w_state);
        end
        checks++;
        if (w_word_count !== (c_ADDR_W + 1)'(exp_cnt)) begin
            errors++;
            $display("FAIL commit_count: word_count=%0d, need %0d", w_word_count, exp_cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({w_wr_en, w_wr_addr, w_wr_data, w_proc_hold, w_busy, w_done,
             w_word_count, w_disp_word, w_state} !== '0) begin
            errors++;
            $display("FAIL reset_values: en=%b addr=%h data=%h hold=%b busy=%b done=%b cnt=%0d disp=%h st=%0d, need all 0",
                     w_wr_en, w_wr_addr, w_wr_data, w_proc_hold, w_busy, w_done,
                     w_word_count, w_disp_word, w_state);
        end
        rst = 1'b0;
        // nibble edges in IDLE must not be captured
        send_nib(4'hF);
        checks++;
        if (w_state !== 2'd0 || w_disp_word !== '0) begin
            errors++;
            $display("FAIL idle_ignore: state=%0d disp=%h, need 0/0000", w_state, w_disp_word);
        end
    endtask

    task automatic test_single_word();
        wq.delete();
        do_start();
        send_nib(4'h2);
        send_nib(4'h0);
        send_nib(4'hA);
        r_nib       = 4'h1;
        r_nib_valid = 1'b1;
        @(negedge clk);
        r_nib_valid = 1'b0;
        checks++;
        if (w_wr_en !== 1'b1 || w_wr_addr !== 5'd0 || w_wr_data !== 16'h20A1 || w_state !== 2'd2) begin
            errors++;
            $display("FAIL single_write: en=%b addr=%0d data=%h st=%0d, need 1/0/20a1/2",
                     w_wr_en, w_wr_addr, w_wr_data, w_state);
        end
        @(negedge clk);
        checks++;
        if (w_wr_en !== 1'b0 || w_word_count !== 6'd1 || w_state !== 2'd1 ||
            w_proc_hold !== 1'b1 || w_disp_word !== '0) begin
            errors++;
            $display("FAIL single_after: en=%b cnt=%0d st=%0d hold=%b disp=%h, need 0/1/1/1/0000",
                     w_wr_en, w_word_count, w_state, w_proc_hold, w_disp_word);
        end
        do_commit(1);
        checks++;
        if (wq.size() != 1) begin
            errors++;
            $display("FAIL single_pulses: saw %0d writes, need 1", wq.size());
        end
    endtask

    task automatic test_program();
        logic [c_DATA_W-1:0] prog [9];
        prog = '{16'h20A1, 16'h21A2, 16'h2033, 16'h28A4, 16'h4125,
                 16'h3536, 16'h4640, 16'h10BB, 16'h5000};
        wq.delete();
        do_start();
        foreach (prog[i]) send_word(prog[i]);
        do_commit(9);
        checks++;
        if (wq.size() != 9) begin
            errors++;
            $display("FAIL program_pulses: saw %0d writes, need 9", wq.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (wq[i].a !== 5'(i) || wq[i].d !== prog[i]) begin
                    errors++;
                    $display("FAIL program_word%0d: addr=%0d data=%h, need addr=%0d data=%h",
                             i, wq[i].a, wq[i].d, i, prog[i]);
                end
            end
        end
    endtask

    task automatic test_full_memory();
        logic [c_DATA_W-1:0] mem [c_DEPTH];
        int                  bad;
        wq.delete();
        foreach (mem[i]) mem[i] = c_DATA_W'($urandom);
        do_start();
        for (int i = 0; i < c_DEPTH - 1; i++) send_word(mem[i]);
        for (int j = 0; j < 3; j++) send_nib(4'(mem[c_DEPTH-1] >> (12 - 4 * j)));
        r_nib       = 4'(mem[c_DEPTH-1]);
        r_nib_valid = 1'b1;
        @(negedge clk);
        r_nib_valid = 1'b0;
        checks++;
        if (w_wr_en !== 1'b1 || w_wr_addr !== 5'(c_DEPTH - 1) || w_wr_data !== mem[c_DEPTH-1]) begin
            errors++;
            $display("FAIL full_last_write: en=%b addr=%0d data=%h, need 1/%0d/%h",
                     w_wr_en, w_wr_addr, w_wr_data, c_DEPTH - 1, mem[c_DEPTH-1]);
        end
        @(negedge clk);
        checks++;
        if (w_done !== 1'b1 || w_state !== 2'd3 || w_word_count !== 6'(c_DEPTH)) begin
            errors++;
            $display("FAIL full_auto_done: done=%b st=%0d cnt=%0d, need 1/3/%0d",
                     w_done, w_state, w_word_count, c_DEPTH);
        end
        @(negedge clk);
        checks++;
        if (w_state !== 2'd0 || w_proc_hold !== 1'b0 || w_done !== 1'b0) begin
            errors++;
            $display("FAIL full_idle: st=%0d hold=%b done=%b, need 0/0/0", w_state, w_proc_hold, w_done);
        end
        for (int j = 0; j < 6; j++) send_nib(4'($urandom));
        checks++;
        if (wq.size() != c_DEPTH || w_disp_word !== '0 || w_word_count !== 6'(c_DEPTH)) begin
            errors++;
            $display("FAIL full_pulses: writes=%0d disp=%h cnt=%0d, need %0d/0000/%0d",
                     wq.size(), w_disp_word, w_word_count, c_DEPTH, c_DEPTH);
        end
        bad = 0;
        for (int i = 0; i < wq.size() && i < c_DEPTH; i++) begin
            if (wq[i].a !== 5'(i) || wq[i].d !== mem[i]) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL full_contents: %0d writes differ from the reference memory, need 0", bad);
        end
    endtask

    task automatic test_partial_commit();
        wq.delete();
        do_start();
        send_nib(4'hA);
        send_nib(4'hB);
        checks++;
        if (w_disp_word !== 16'h00AB) begin
            errors++;
            $display("FAIL partial_disp: disp=%h, need 00ab", w_disp_word);
        end
        do_commit(0);
        checks++;
        if (wq.size() != 0) begin
            errors++;
            $display("FAIL partial_nowrite: saw %0d writes, need 0", wq.size());
        end
        do_start();
        checks++;
        if (w_disp_word !== '0 || w_word_count !== '0) begin
            errors++;
            $display("FAIL partial_restart: disp=%h cnt=%0d, need 0000/0", w_disp_word, w_word_count);
        end
        do_commit(0);
    endtask

    task automatic test_hold_and_collision();
        logic [3:0] v;
        logic [3:0] w;
        wq.delete();
        v = 4'($urandom);
        w = 4'($urandom);
        do_start();
        r_nib       = v;
        r_nib_valid = 1'b1;
        repeat (10) @(negedge clk);
        r_nib_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (w_disp_word !== 16'(v) || w_state !== 2'd1) begin
            errors++;
            $display("FAIL hold_single: disp=%h st=%0d, need %h/1", w_disp_word, w_state, 16'(v));
        end
        r_nib       = w;
        r_nib_valid = 1'b1;
        r_commit    = 1'b1;
        @(negedge clk);
        r_commit    = 1'b0;
        r_nib_valid = 1'b0;
        checks++;
        if (w_state !== 2'd3 || w_done !== 1'b1 || w_disp_word !== 16'(v)) begin
            errors++;
            $display("FAIL commit_wins: st=%0d done=%b disp=%h, need 3/1/%h",
                     w_state, w_done, w_disp_word, 16'(v));
        end
        @(negedge clk);
        checks++;
        if (w_state !== 2'd0 || wq.size() != 0) begin
            errors++;
            $display("FAIL collision_end: st=%0d writes=%0d, need 0/0", w_state, wq.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [c_DATA_W-1:0] w1, w2, w3;
        wq.delete();
        w1 = c_DATA_W'($urandom);
        w2 = c_DATA_W'($urandom);
        w3 = c_DATA_W'($urandom);
        do_start();
        send_word(w1);
        for (int j = 0; j < 3; j++) send_nib(4'(w2 >> (12 - 4 * j)));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({w_wr_en, w_wr_addr, w_wr_data, w_proc_hold, w_busy, w_done,
             w_word_count, w_disp_word, w_state} !== '0) begin
            errors++;
            $display("FAIL midreset_values: en=%b addr=%h data=%h hold=%b busy=%b done=%b cnt=%0d disp=%h st=%0d, need all 0",
                     w_wr_en, w_wr_addr, w_wr_data, w_proc_hold, w_busy, w_done,
                     w_word_count, w_disp_word, w_state);
        end
        checks++;
        if (wq.size() != 1) begin
            errors++;
            $display("FAIL midreset_writes: saw %0d writes, need 1", wq.size());
        end
        do_start();
        send_word(w3);
        checks++;
        if (wq.size() != 2 || wq[wq.size()-1].a !== 5'd0 || wq[wq.size()-1].d !== w3) begin
            errors++;
            $display("FAIL midreset_fresh: writes=%0d last addr=%0d data=%h, need 2/0/%h",
                     wq.size(), wq[wq.size()-1].a, wq[wq.size()-1].d, w3);
        end
        do_commit(1);
    endtask

    task automatic test_back_to_back();
        logic [c_DATA_W-1:0] ws [$];
        int                  nw;
        int                  bad;
        wq.delete();
        nw = $urandom_range(3, 7);
        do_start();
        for (int i = 0; i < nw; i++) begin
            ws.push_back(c_DATA_W'($urandom));
            for (int j = 0; j < 4; j++) begin
                send_nib(4'(ws[i] >> (12 - 4 * j)));
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        do_commit(nw);
        bad = (wq.size() != nw) ? 1 : 0;
        for (int i = 0; i < wq.size() && i < nw; i++) begin
            if (wq[i].a !== 5'(i) || wq[i].d !== ws[i]) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL back_to_back: writes=%0d, %0d mismatching entries, need %0d writes, 0 bad",
                     wq.size(), bad, nw);
        end
    endtask

    initial begin
        rst         = 1'b1;
        r_start     = 1'b0;
        r_nib       = 4'h0;
        r_nib_valid = 1'b0;
        r_commit    = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_word();
        test_program();
        test_full_memory();
        test_partial_commit();
        test_hold_and_collision();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
